// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for the 1-bit ALU cell: latches operands and mode on START,
// then issues one bit pair per clock (LSB first), chains the carry and rebuilds the result.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  input  logic             CARRY_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY_OUT,
  output logic [2:0]       ALU_MODE,
  output logic             ALU_A,
  output logic             ALU_B,
  output logic             ALU_CIN,
  input  logic             ALU_X,
  input  logic             ALU_COUT
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] MODE_PLUS = 3'b000;
  localparam logic [2:0] MODE_MAX  = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [2:0]       mode_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             err_q;
  logic             legal, accept, last_bit;

  assign legal    = (MODE <= MODE_MAX);
  assign accept   = (state_q != RUN) && START && legal;
  assign last_bit = (cnt == CW'(WIDTH-1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FIN: state_d = accept ? RUN : IDLE;
      RUN:       if (last_bit) state_d = FIN;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY     = 1'b0;
    DONE     = 1'b0;
    ALU_MODE = 3'b000;
    ALU_A    = 1'b0;
    ALU_B    = 1'b0;
    ALU_CIN  = 1'b0;
    case (state_q)
      RUN: begin
        BUSY     = 1'b1;
        ALU_MODE = mode_q;
        ALU_A    = a_sr[0];
        ALU_B    = b_sr[0];
        ALU_CIN  = carry_q;
      end
      FIN:     DONE = 1'b1;
      default: ;
    endcase
  end

  assign ERR = err_q;

  // The cell's carry is registered here, so bit i+1 sees bit i's C_out one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      mode_q    <= 3'b000;
      carry_q   <= 1'b0;
      cnt       <= '0;
      err_q     <= 1'b0;
      RESULT    <= '0;
      CARRY_OUT <= 1'b0;
    end else begin
      err_q <= (state_q != RUN) && START && !legal;
      if (state_q == RUN) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        res_sr  <= {ALU_X, res_sr[WIDTH-1:1]};
        carry_q <= ALU_COUT;
        cnt     <= cnt + CW'(1);
        if (last_bit) begin
          RESULT    <= {ALU_X, res_sr[WIDTH-1:1]};
          CARRY_OUT <= (mode_q == MODE_PLUS) && ALU_COUT;
        end
      end else if (accept) begin
        a_sr    <= OP_A;
        b_sr    <= OP_B;
        mode_q  <= MODE;
        carry_q <= (MODE == MODE_PLUS) && CARRY_IN;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit ALU cell as the responder.
module tb_alu_serial_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [2:0] MODE = 3'b000;
  logic [7:0] OP_A = 8'h00;
  logic [7:0] OP_B = 8'h00;
  logic       CARRY_IN = 1'b0;
  logic       BUSY, DONE, ERR, CARRY_OUT;
  logic [7:0] RESULT;
  logic [2:0] ALU_MODE;
  logic       ALU_A, ALU_B, ALU_CIN;
  logic       ALU_X, ALU_COUT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  int prev_done = 0;

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
    .OP_A(OP_A), .OP_B(OP_B), .CARRY_IN(CARRY_IN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RESULT(RESULT), .CARRY_OUT(CARRY_OUT),
    .ALU_MODE(ALU_MODE), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN),
    .ALU_X(ALU_X), .ALU_COUT(ALU_COUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // 1-bit ALU cell: plus uses C_in, logic modes ignore it and report C_out=0
  always_comb begin
    ALU_X    = 1'b0;
    ALU_COUT = 1'b0;
    case (ALU_MODE)
      3'b000: begin
        ALU_X    = ALU_A ^ ALU_B ^ ALU_CIN;
        ALU_COUT = (ALU_A & ALU_B) | (ALU_CIN & (ALU_A ^ ALU_B));
      end
      3'b001:  ALU_X = ALU_A & ALU_B;
      3'b010:  ALU_X = ALU_A | ALU_B;
      3'b011:  ALU_X = ALU_A ^ ALU_B;
      3'b100:  ALU_X = ~(ALU_A ^ ALU_B);
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue START in the current (non-RUN) cycle and follow the op to its DONE.
  // inj >= 0 pulses a stray START with OP_A=0x01 in that RUN cycle.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [7:0] a,
                        input logic [7:0] b, input logic ci, input logic [7:0] er,
                        input logic ec, input int inj);
    int n, busy_n, err_n;
    MODE = m; OP_A = a; OP_B = b; CARRY_IN = ci; START = 1'b1;
    tick();
    START = 1'b0;
    chk({tag, "_mode"}, ALU_MODE, m);
    chk({tag, "_a0"}, ALU_A, a[0]);
    chk({tag, "_b0"}, ALU_B, b[0]);
    chk({tag, "_cin0"}, ALU_CIN, (m == 3'b000) ? ci : 1'b0);
    n = 0; busy_n = 0; err_n = 0;
    while (!DONE && n < 20) begin
      if (BUSY) busy_n++;
      if (ERR) err_n++;
      if (n == inj) begin START = 1'b1; OP_A = 8'h01; end
      else START = 1'b0;
      tick();
      n++;
    end
    START = 1'b0;
    chk({tag, "_done"}, DONE, 1'b1);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busy"}, busy_n, 8);
    chk({tag, "_err"}, err_n, 0);
    chk({tag, "_res"}, RESULT, er);
    chk({tag, "_cout"}, CARRY_OUT, ec);
    last_done = cyc;
  endtask

  initial begin
    int cnt_d, cnt_b;
    tick(); tick();
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_res", RESULT, 8'h00);
    chk("rst_cout", CARRY_OUT, 1'b0);
    chk("rst_amode", ALU_MODE, 3'b000);
    chk("rst_alu", {ALU_A, ALU_B, ALU_CIN}, 3'b000);
    RST = 1'b0;
    tick();

    run_op("add_ff01", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
    tick();
    chk("done_pulse", DONE, 1'b0);
    chk("idle_busy", BUSY, 1'b0);
    run_op("add_3c05", 3'b000, 8'h3C, 8'h05, 1'b1, 8'h42, 1'b0, -1);
    tick();

    run_op("and", 3'b001, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, -1);
    prev_done = last_done;
    run_op("or", 3'b010, 8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0, -1);
    chk("b2b_or", last_done - prev_done, 9);
    prev_done = last_done;
    run_op("xor", 3'b011, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, -1);
    chk("b2b_xor", last_done - prev_done, 9);
    prev_done = last_done;
    run_op("xnor", 3'b100, 8'hAA, 8'h0F, 1'b0, 8'h5A, 1'b0, -1);
    chk("b2b_xnor", last_done - prev_done, 9);
    tick();

    MODE = 3'b101; OP_A = 8'h11; OP_B = 8'h22; START = 1'b1;
    tick();
    START = 1'b0;
    chk("ill_err", ERR, 1'b1);
    chk("ill_busy", BUSY, 1'b0);
    chk("ill_done", DONE, 1'b0);
    tick();
    chk("ill_err_clr", ERR, 1'b0);
    cnt_d = 0; cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE) cnt_d++;
      if (BUSY) cnt_b++;
      tick();
    end
    chk("ill_nodone", cnt_d, 0);
    chk("ill_nobusy", cnt_b, 0);
    chk("ill_res", RESULT, 8'h5A);

    run_op("ign", 3'b000, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);
    tick();
    chk("ign_one_done", DONE, 1'b0);
    chk("ign_idle", BUSY, 1'b0);
    tick();

    MODE = 3'b000; OP_A = 8'hFF; OP_B = 8'hFF; CARRY_IN = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy", BUSY, 1'b1);
    chk("mid_a3", ALU_A, 1'b1);
    chk("mid_cin3", ALU_CIN, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", BUSY, 1'b0);
    chk("arst_alu", {ALU_MODE, ALU_A, ALU_B, ALU_CIN}, 6'b0);
    chk("arst_res", RESULT, 8'h00);
    chk("arst_cout", CARRY_OUT, 1'b0);
    tick();
    RST = 1'b0;
    cnt_d = 0;
    for (int i = 0; i < 12; i++) begin
      if (DONE || BUSY) cnt_d++;
      tick();
    end
    chk("arst_quiet", cnt_d, 0);
    run_op("post_rst", 3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, -1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
